// File: rtl/remote_comm_pkg.sv
// Shared types and constants for the remote command initiator.
package remote_comm_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    XMIT,
    RESP_WAIT
  } state_e;

endpackage

// File: rtl/remote_comm_uart.sv
// 8N1 UART transceiver: one-cycle tx_done pulse per frame, rdy level held until clr_rdy.
module remote_comm_uart #(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done,
  input  logic       RX,
  output logic       rdy,
  output logic [7:0] rx_data,
  input  logic       clr_rdy
);

  localparam int unsigned BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BIT_LAST  = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(BAUD_DIV / 2 - 1);

  logic          tx_busy_q, tx_busy_d;
  logic [BW-1:0] tx_baud_q, tx_baud_d;
  logic [3:0]    tx_bits_q, tx_bits_d;
  logic [9:0]    tx_shift_q, tx_shift_d;
  logic          tx_done_q, tx_done_d;

  logic          rx_meta_q, rx_sync_q;
  logic          rx_busy_q, rx_busy_d;
  logic [BW-1:0] rx_baud_q, rx_baud_d;
  logic [3:0]    rx_bits_q, rx_bits_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rdy_q, rdy_d;

  always_comb begin
    tx_busy_d  = tx_busy_q;
    tx_baud_d  = tx_baud_q;
    tx_bits_d  = tx_bits_q;
    tx_shift_d = tx_shift_q;
    tx_done_d  = 1'b0;
    if (!tx_busy_q) begin
      if (trmt) begin
        tx_busy_d  = 1'b1;
        tx_shift_d = {1'b1, tx_data, 1'b0};
        tx_baud_d  = BIT_LAST;
        tx_bits_d  = 4'd0;
      end
    end else if (tx_baud_q != '0) begin
      tx_baud_d = tx_baud_q - 1'b1;
    end else if (tx_bits_q == 4'd9) begin
      tx_busy_d = 1'b0;
      tx_done_d = 1'b1;
    end else begin
      tx_shift_d = {1'b1, tx_shift_q[9:1]};
      tx_bits_d  = tx_bits_q + 1'b1;
      tx_baud_d  = BIT_LAST;
    end
  end

  // Sample 0 is mid start bit, 1..8 are data LSB first, 9 is the stop bit.
  always_comb begin
    rx_busy_d  = rx_busy_q;
    rx_baud_d  = rx_baud_q;
    rx_bits_d  = rx_bits_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rdy_d      = rdy_q & ~clr_rdy;
    if (!rx_busy_q) begin
      if (!rx_sync_q) begin
        rx_busy_d = 1'b1;
        rx_baud_d = HALF_LAST;
        rx_bits_d = 4'd0;
      end
    end else if (rx_baud_q != '0) begin
      rx_baud_d = rx_baud_q - 1'b1;
    end else begin
      rx_baud_d = BIT_LAST;
      rx_bits_d = rx_bits_q + 1'b1;
      if (rx_bits_q == 4'd0) begin
        if (rx_sync_q) rx_busy_d = 1'b0;
      end else if (rx_bits_q == 4'd9) begin
        rx_busy_d = 1'b0;
        rx_data_d = rx_shift_q;
        rdy_d     = 1'b1;
      end else begin
        rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy_q  <= 1'b0;
      tx_baud_q  <= '0;
      tx_bits_q  <= 4'd0;
      tx_shift_q <= '1;
      tx_done_q  <= 1'b0;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_busy_q  <= 1'b0;
      rx_baud_q  <= '0;
      rx_bits_q  <= 4'd0;
      rx_shift_q <= 8'h00;
      rx_data_q  <= 8'h00;
      rdy_q      <= 1'b0;
    end else begin
      tx_busy_q  <= tx_busy_d;
      tx_baud_q  <= tx_baud_d;
      tx_bits_q  <= tx_bits_d;
      tx_shift_q <= tx_shift_d;
      tx_done_q  <= tx_done_d;
      rx_meta_q  <= RX;
      rx_sync_q  <= rx_meta_q;
      rx_busy_q  <= rx_busy_d;
      rx_baud_q  <= rx_baud_d;
      rx_bits_q  <= rx_bits_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rdy_q      <= rdy_d;
    end
  end

  assign TX      = tx_busy_q ? tx_shift_q[0] : 1'b1;
  assign tx_done = tx_done_q;
  assign rdy     = rdy_q;
  assign rx_data = rx_data_q;

endmodule

// File: rtl/remote_comm.sv
// Host-side command initiator: sends NUM_BYTES command bytes MSB first over the UART,
// then waits for one response byte or a timeout.
module remote_comm #(
  parameter int unsigned NUM_BYTES    = 3,
  parameter int unsigned RESP_TIMEOUT = 2_000_000,
  parameter int unsigned BAUD_DIV     = 434
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 snd_cmd,
  input  logic [8*NUM_BYTES-1:0] cmd,
  input  logic                 clr_resp_rdy,
  input  logic                 RX,
  output logic                 TX,
  output logic                 busy,
  output logic                 cmd_sent,
  output logic [7:0]           resp,
  output logic                 resp_rdy,
  output logic                 timeout
);
  import remote_comm_pkg::*;

  localparam int unsigned CMD_W = BYTE_W * NUM_BYTES;
  localparam int unsigned TW    = $clog2(RESP_TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST    = TW'(RESP_TIMEOUT - 1);
  localparam logic [1:0]    LAST_BYTE = 2'(NUM_BYTES - 1);

  state_e            state_q, state_d;
  logic [CMD_W-1:0]  shift_q, shift_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic              cmd_sent_q, cmd_sent_d;
  logic [BYTE_W-1:0] resp_q, resp_d;
  logic              resp_rdy_q, resp_rdy_d;
  logic              timeout_q, timeout_d;
  logic              clr_rdy_q, clr_rdy_d;

  logic              trmt, tx_done, rdy;
  logic [BYTE_W-1:0] tx_data, rx_data;

  // rdy stays high one cycle after clr_rdy; clr_rdy_q masks that stale cycle.
  logic rdy_new;
  assign rdy_new = rdy & ~clr_rdy_q;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    tcnt_d     = tcnt_q;
    cmd_sent_d = cmd_sent_q;
    resp_d     = resp_q;
    resp_rdy_d = resp_rdy_q & ~clr_resp_rdy;
    timeout_d  = timeout_q;
    clr_rdy_d  = 1'b0;
    trmt       = 1'b0;

    if (rdy_new && state_q != RESP_WAIT) clr_rdy_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (snd_cmd) begin
          shift_d    = cmd;
          cnt_d      = 2'd0;
          cmd_sent_d = 1'b0;
          timeout_d  = 1'b0;
          resp_rdy_d = 1'b0;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        trmt    = 1'b1;
        state_d = XMIT;
      end
      XMIT: begin
        if (tx_done) begin
          if (cnt_q != LAST_BYTE) begin
            shift_d = shift_q << BYTE_W;
            cnt_d   = cnt_q + 1'b1;
            state_d = LOAD;
          end else begin
            cmd_sent_d = 1'b1;
            tcnt_d     = '0;
            state_d    = RESP_WAIT;
          end
        end
      end
      RESP_WAIT: begin
        if (tcnt_q != '1) tcnt_d = tcnt_q + 1'b1;
        if (rdy_new) begin
          resp_d     = rx_data;
          resp_rdy_d = 1'b1;
          clr_rdy_d  = 1'b1;
          state_d    = IDLE;
        end else if (tcnt_q == T_LAST) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= 2'd0;
      tcnt_q     <= '0;
      cmd_sent_q <= 1'b0;
      resp_q     <= '0;
      resp_rdy_q <= 1'b0;
      timeout_q  <= 1'b0;
      clr_rdy_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      tcnt_q     <= tcnt_d;
      cmd_sent_q <= cmd_sent_d;
      resp_q     <= resp_d;
      resp_rdy_q <= resp_rdy_d;
      timeout_q  <= timeout_d;
      clr_rdy_q  <= clr_rdy_d;
    end
  end

  assign tx_data = shift_q[CMD_W-1 -: BYTE_W];

  remote_comm_uart #(
    .BAUD_DIV(BAUD_DIV)
  ) u_uart (
    .clk    (clk),
    .rst_n  (rst_n),
    .trmt   (trmt),
    .tx_data(tx_data),
    .TX     (TX),
    .tx_done(tx_done),
    .RX     (RX),
    .rdy    (rdy),
    .rx_data(rx_data),
    .clr_rdy(clr_rdy_q)
  );

  assign busy     = (state_q != IDLE);
  assign cmd_sent = cmd_sent_q;
  assign resp     = resp_q;
  assign resp_rdy = resp_rdy_q;
  assign timeout  = timeout_q;

endmodule
